// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Drains a synchronous FIFO (rden/empty/rddata, 1-cycle read latency) and
// re-presents its words as a valid/ready stream. A 3-entry skid buffer holds
// words already read so the FIFO read enable never depends on m_ready.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   i_enable       permits new FIFO pops (buffered/in-flight words still drain)
//   o_rden         FIFO read enable
//   i_empty        FIFO empty flag
//   i_rddata       FIFO read data, valid the cycle after o_rden
//   m_valid/m_data/m_ready   output stream
//   o_busy         buffer non-empty or a read in flight
//   o_xfer_cnt     count of accepted stream words (wraps)
module fifo_rd_stream_adapter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    output logic              o_rden,
    input  logic              i_empty,
    input  logic [DATA_W-1:0] i_rddata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_xfer_cnt
);

    logic [DATA_W-1:0] r_buf [3];
    logic [1:0]        r_head;
    logic [1:0]        r_tail;
    logic [1:0]        r_occ;
    logic              r_pend;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_pop;
    logic [2:0]        w_fill;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for the in-flight word too, so the buffer cannot
    // overflow even when m_ready is held low indefinitely.
    assign w_fill     = {1'b0, r_occ} + {2'b00, r_pend};
    assign o_rden     = ~reset & i_enable & ~i_empty & (w_fill < 3'd3);
    assign m_valid    = (r_occ != 2'd0);
    assign w_pop      = m_valid & m_ready;
    assign o_busy     = m_valid | r_pend;
    assign o_xfer_cnt = r_cnt;

    always_comb begin
        m_data = r_buf[0];
        if (r_head == 2'd1) m_data = r_buf[1];
        if (r_head == 2'd2) m_data = r_buf[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
            r_head <= 2'd0;
            r_tail <= 2'd0;
            r_occ  <= 2'd0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pend <= o_rden;
            // Capture the word read last cycle at the tail.
            if (r_pend) begin
                for (int i = 0; i < 3; i++)
                    if (r_tail == 2'(i)) r_buf[i] <= i_rddata;
                r_tail <= nxt(r_tail);
            end
            if (w_pop) begin
                r_head <= nxt(r_head);
                r_cnt  <= r_cnt + 1'b1;
            end
            // Capture and pop in the same cycle cancel out.
            r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

endmodule
